// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: registered command decoder and run controller for a stopwatch.
//
// Decodes command words (START / PAUSE / LAP / STOP) into a three-state run
// controller (IDLE / RUN / PAUSED). Owns the elapsed-tick counter, emits
// one-cycle capture strobes for the result store and a restart strobe after STOP.
//
// Optional feature macro: STOPWATCH_SATURATE_EN
//   defined   -> the counter saturates at all-ones
//   undefined -> the counter wraps from all-ones to zero (default)
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_pulse       one-cycle tick strobe
//   i_valid_read  i_data_in holds a command this cycle
//   i_data_in     command word
//   o_increment   combinational: pulse while running
//   o_wr_en       one-cycle write strobe for a captured count
//   o_wr_data     captured count, valid while o_wr_en=1
//   o_restart     one-cycle strobe after STOP
//   o_count       current tick count
//   o_state       IDLE=0, RUN=1, PAUSED=2
//   o_overflow    sticky: counter hit its maximum while counting
//   o_cmd_err     one-cycle strobe for an unknown command code
module stopwatch_ctrl #(
    parameter int unsigned          DATA_SIZE  = 32,
    parameter int unsigned          CNT_WIDTH  = 32,
    parameter logic [DATA_SIZE-1:0] START_CODE = {DATA_SIZE{1'b1}},
    parameter logic [DATA_SIZE-1:0] STOP_CODE  = {DATA_SIZE{1'b0}},
    parameter logic [DATA_SIZE-1:0] PAUSE_CODE = {DATA_SIZE{1'b1}} >> 16,
    parameter logic [DATA_SIZE-1:0] LAP_CODE   = {DATA_SIZE{1'b1}} >> 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_pulse,
    input  logic                 i_valid_read,
    input  logic [DATA_SIZE-1:0] i_data_in,
    output logic                 o_increment,
    output logic                 o_wr_en,
    output logic [CNT_WIDTH-1:0] o_wr_data,
    output logic                 o_restart,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic [1:0]           o_state,
    output logic                 o_overflow,
    output logic                 o_cmd_err
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StPaused = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e r_state;
    state_e w_state_d;

    logic                 w_start;
    logic                 w_stop;
    logic                 w_pause;
    logic                 w_lap;
    logic                 w_unknown;
    logic                 w_increment;
    logic                 w_capture;
    logic [CNT_WIDTH-1:0] w_count_d;
    logic                 w_overflow_d;

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] r_wr_data;
    logic                 r_wr_en;
    logic                 r_restart;
    logic                 r_overflow;
    logic                 r_cmd_err;

    // STOP is decoded first so overlapping code parameters still behave sanely.
    always_comb begin
        w_start   = 1'b0;
        w_stop    = 1'b0;
        w_pause   = 1'b0;
        w_lap     = 1'b0;
        w_unknown = 1'b0;
        if (i_valid_read) begin
            if (i_data_in == STOP_CODE)        w_stop    = 1'b1;
            else if (i_data_in == START_CODE)  w_start   = 1'b1;
            else if (i_data_in == PAUSE_CODE)  w_pause   = 1'b1;
            else if (i_data_in == LAP_CODE)    w_lap     = 1'b1;
            else                               w_unknown = 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= StIdle;
        else          r_state <= w_state_d;
    end

    // FSM: next state
    always_comb begin
        w_state_d = r_state;
        if (w_stop) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle:   if (w_start) w_state_d = StRun;
                StRun:    if (w_pause) w_state_d = StPaused;
                StPaused: if (w_start) w_state_d = StRun;
                default:  w_state_d = StIdle;
            endcase
        end
    end

    // FSM: outputs. Both depend on the pre-command state, so a pulse in a
    // START cycle is dropped and a pulse in a PAUSE cycle is counted.
    always_comb begin
        w_increment = i_pulse && (r_state == StRun);
        w_capture   = (r_state == StRun) && (w_pause || w_lap);
    end

    // Counter next value; STOP clears and discards any same-cycle pulse.
    always_comb begin
        w_count_d    = r_count;
        w_overflow_d = r_overflow;
        if (w_stop) begin
            w_count_d    = '0;
            w_overflow_d = 1'b0;
        end else if (w_increment) begin
            if (r_count == CntMax) begin
                w_overflow_d = 1'b1;
`ifdef STOPWATCH_SATURATE_EN
                w_count_d    = CntMax;
`else
                w_count_d    = '0;
`endif
            end else begin
                w_count_d = r_count + CntOne;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count    <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
            r_restart  <= 1'b0;
            r_overflow <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_count    <= w_count_d;
            r_overflow <= w_overflow_d;
            r_wr_en    <= w_capture;
            r_restart  <= w_stop;
            r_cmd_err  <= w_unknown;
            // Captured value includes a same-cycle pulse.
            if (w_capture) r_wr_data <= w_count_d;
        end
    end

    assign o_increment = w_increment;
    assign o_wr_en     = r_wr_en;
    assign o_wr_data   = r_wr_data;
    assign o_restart   = r_restart;
    assign o_count     = r_count;
    assign o_state     = r_state;
    assign o_overflow  = r_overflow;
    assign o_cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    localparam logic [31:0] C_START = 32'hFFFF_FFFF;
    localparam logic [31:0] C_STOP  = 32'h0000_0000;
    localparam logic [31:0] C_PAUSE = 32'h0000_FFFF;
    localparam logic [31:0] C_LAP   = 32'h00FF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pulse;
    logic          valid_read;
    logic [31:0]   data_in;
    logic          increment;
    logic          wr_en;
    logic [CW-1:0] wr_data;
    logic          restart;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic          overflow;
    logic          cmd_err;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers, updated once per clock edge.
    int m_state;   // 0 idle, 1 run, 2 paused
    int m_count;
    int m_wr_data;
    bit m_ovf;
    bit m_wr_en;
    bit m_restart;
    bit m_err;

    stopwatch_ctrl #(
        .DATA_SIZE (32),
        .CNT_WIDTH (CW)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pulse      (pulse),
        .i_valid_read (valid_read),
        .i_data_in    (data_in),
        .o_increment  (increment),
        .o_wr_en      (wr_en),
        .o_wr_data    (wr_data),
        .o_restart    (restart),
        .o_count      (count),
        .o_state      (state),
        .o_overflow   (overflow),
        .o_cmd_err    (cmd_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_state   = 0;
        m_count   = 0;
        m_wr_data = 0;
        m_ovf     = 1'b0;
        m_wr_en   = 1'b0;
        m_restart = 1'b0;
        m_err     = 1'b0;
    endfunction

    function automatic void model_step(bit v, logic [31:0] d, bit p);
        bit is_start = v && (d == C_START);
        bit is_stop  = v && (d == C_STOP);
        bit is_pause = v && (d == C_PAUSE);
        bit is_lap   = v && (d == C_LAP);
        bit counts   = p && (m_state == 1);
        m_err     = v && !(is_start || is_stop || is_pause || is_lap);
        m_restart = is_stop;
        m_wr_en   = 1'b0;
        if (is_stop) begin
            m_state = 0;
            m_count = 0;
            m_ovf   = 1'b0;
        end else begin
            if (counts) begin
                if (m_count == MAXC) begin
                    m_ovf = 1'b1;
`ifdef STOPWATCH_SATURATE_EN
                    m_count = MAXC;
`else
                    m_count = 0;
`endif
                end else begin
                    m_count = m_count + 1;
                end
            end
            if (m_state == 1 && (is_pause || is_lap)) begin
                m_wr_en   = 1'b1;
                m_wr_data = m_count;
            end
            if (is_start && m_state != 1)      m_state = 1;
            else if (is_pause && m_state == 1) m_state = 2;
        end
    endfunction

    // One clock cycle of stimulus; checks the combinational increment before the edge.
    task automatic cyc(input bit v, input logic [31:0] d, input bit p);
        valid_read = v;
        data_in    = d;
        pulse      = p;
        #1;
        checks++;
        if (increment !== (p && m_state == 1)) begin
            errors++;
            $display("FAIL increment: got %b expected %b", increment, (p && m_state == 1));
        end
        @(posedge clk);
        model_step(v, d, p);
        #1;
        valid_read = 1'b0;
        pulse      = 1'b0;
        data_in    = $urandom;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        pulse      = 1'b0;
        valid_read = 1'b0;
        data_in    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({state, count, wr_data, wr_en, restart, overflow, cmd_err} !== '0) begin
            errors++;
            $display("FAIL reset_values: got st=%0d cnt=%0d wd=%0d we=%b rs=%b ov=%b ce=%b expected all 0",
                     state, count, wr_data, wr_en, restart, overflow, cmd_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_run();
        bit saw_wr = 1'b0;
        cyc(1, C_STOP, 0);
        cyc(1, C_START, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 32'h0, 1);
            if (wr_en) saw_wr = 1'b1;
        end
        checks++;
        if (state !== 2'd1 || count !== 4'd5 || saw_wr) begin
            errors++;
            $display("FAIL run_5_pulses: got st=%0d cnt=%0d wr_seen=%b expected st=1 cnt=5 wr_seen=0",
                     state, count, saw_wr);
        end
    endtask

    task automatic test_pause();
        cyc(1, C_STOP, 0);
        cyc(1, C_START, 0);
        for (int i = 0; i < 7; i++) cyc(0, 32'h0, 1);
        cyc(1, C_PAUSE, 1);
        checks++;
        if (wr_en !== 1'b1 || wr_data !== 4'd8 || state !== 2'd2) begin
            errors++;
            $display("FAIL pause_capture: got we=%b wd=%0d st=%0d expected we=1 wd=8 st=2",
                     wr_en, wr_data, state);
        end
        cyc(0, 32'h0, 1);
        cyc(0, 32'h0, 1);
        checks++;
        if (wr_en !== 1'b0 || count !== 4'd8) begin
            errors++;
            $display("FAIL pause_hold: got we=%b cnt=%0d expected we=0 cnt=8", wr_en, count);
        end
    endtask

    task automatic test_lap();
        cyc(1, C_STOP, 0);
        cyc(1, C_START, 0);
        for (int i = 0; i < 3; i++) cyc(0, 32'h0, 1);
        cyc(1, C_LAP, 0);
        checks++;
        if (wr_en !== 1'b1 || wr_data !== 4'd3) begin
            errors++;
            $display("FAIL lap_first: got we=%b wd=%0d expected we=1 wd=3", wr_en, wr_data);
        end
        cyc(0, 32'h0, 1);
        checks++;
        if (wr_en !== 1'b0) begin
            errors++;
            $display("FAIL lap_one_cycle: got we=%b expected 0", wr_en);
        end
        cyc(0, 32'h0, 1);
        cyc(1, C_LAP, 0);
        checks++;
        if (wr_en !== 1'b1 || wr_data !== 4'd5 || state !== 2'd1) begin
            errors++;
            $display("FAIL lap_second: got we=%b wd=%0d st=%0d expected we=1 wd=5 st=1",
                     wr_en, wr_data, state);
        end
    endtask

    task automatic test_overflow();
        int exp_cnt;
`ifdef STOPWATCH_SATURATE_EN
        exp_cnt = MAXC;
`else
        exp_cnt = 0;
`endif
        cyc(1, C_STOP, 0);
        cyc(1, C_START, 0);
        for (int i = 0; i < 16; i++) cyc(0, 32'h0, 1);
        checks++;
        if (count !== exp_cnt[CW-1:0] || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow: got cnt=%0d ov=%b expected cnt=%0d ov=1", count, overflow, exp_cnt);
        end
        cyc(1, C_STOP, 1);
        checks++;
        if (count !== 4'd0 || overflow !== 1'b0 || restart !== 1'b1 || state !== 2'd0) begin
            errors++;
            $display("FAIL stop_clear: got cnt=%0d ov=%b rs=%b st=%0d expected 0 0 1 0",
                     count, overflow, restart, state);
        end
        cyc(0, 32'h0, 0);
        checks++;
        if (restart !== 1'b0) begin
            errors++;
            $display("FAIL restart_one_cycle: got %b expected 0", restart);
        end
    endtask

    task automatic test_cmd_err();
        logic [1:0] st0;
        cyc(1, C_START, 0);
        st0 = state;
        cyc(1, 32'h1234_5678, 0);
        checks++;
        if (cmd_err !== 1'b1 || state !== st0) begin
            errors++;
            $display("FAIL cmd_err_set: got ce=%b st=%0d expected ce=1 st=%0d", cmd_err, state, st0);
        end
        cyc(0, 32'h1234_5678, 0);
        checks++;
        if (cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL cmd_err_ignored: got %b expected 0", cmd_err);
        end
    endtask

    task automatic test_async_reset();
        cyc(1, C_STOP, 0);
        cyc(1, C_START, 0);
        for (int i = 0; i < 9; i++) cyc(0, 32'h0, 1);
        checks++;
        if (count !== 4'd9) begin
            errors++;
            $display("FAIL pre_reset_count: got %0d expected 9", count);
        end
        // Arm a LAP so a strobe is pending, then reset between edges.
        valid_read = 1'b1;
        data_in    = C_LAP;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, count, wr_data, wr_en, restart, overflow, cmd_err} !== '0) begin
            errors++;
            $display("FAIL async_reset: got st=%0d cnt=%0d wd=%0d we=%b rs=%b ov=%b ce=%b expected all 0",
                     state, count, wr_data, wr_en, restart, overflow, cmd_err);
        end
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (wr_en !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: got we=%b cnt=%0d expected 0 0", wr_en, count);
        end
        valid_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(0, 32'h0, 1);
        checks++;
        if (count !== 4'd0 || state !== 2'd0) begin
            errors++;
            $display("FAIL pulse_after_reset: got cnt=%0d st=%0d expected 0 0", count, state);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        bit v;
        bit p;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0:       d = C_START;
                1:       d = C_STOP;
                2:       d = C_PAUSE;
                3:       d = C_LAP;
                4:       d = C_START;
                default: d = $urandom;
            endcase
            // Keep STOP rare so the counter gets a chance to wrap.
            if (d == C_STOP && $urandom_range(0, 3) != 0) d = C_LAP;
            v = ($urandom_range(0, 2) == 0);
            p = ($urandom_range(0, 3) != 0);
            cyc(v, d, p);
            checks++;
            if (state !== m_state[1:0] || count !== m_count[CW-1:0] || overflow !== m_ovf ||
                wr_en !== m_wr_en || restart !== m_restart || cmd_err !== m_err ||
                (m_wr_en && wr_data !== m_wr_data[CW-1:0]) || (wr_en && restart)) begin
                errors++;
                $display("FAIL random[%0d]: got st=%0d cnt=%0d ov=%b we=%b wd=%0d rs=%b ce=%b expected st=%0d cnt=%0d ov=%b we=%b wd=%0d rs=%b ce=%b",
                         i, state, count, overflow, wr_en, wr_data, restart, cmd_err,
                         m_state, m_count, m_ovf, m_wr_en, m_wr_data, m_restart, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause();
        test_lap();
        test_overflow();
        test_cmd_err();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
